// File: rtl/exec_unit.sv
// Multi-cycle execution unit: single-cycle ALU ops, 32-step shift-add multiply and restoring divide.
// One operation in flight; results are written back through a one-cycle WB state.
module exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       dst,
  output logic             busy,
  output logic             done,
  output logic             we,
  output logic [3:0]       wdst,
  output logic [WIDTH-1:0] y,
  output logic             ovf,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;
  localparam logic [3:0] OP_REMU = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ALU  = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]       r_op;
  logic [3:0]       r_dst;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_y;
  logic             r_ovf;
  logic             r_err;

  logic             w_last;
  logic             w_illegal;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_slt;
  logic [WIDTH-1:0] w_alu;
  logic             w_alu_ovf;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_rem_ge;
  logic [WIDTH:0]   w_rem_sub;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;

  assign w_last    = (r_cnt == LAST_STEP);
  assign w_illegal = (r_op > OP_REMU);
  assign w_shamt   = r_b[SHW-1:0];
  assign w_sum     = r_a + r_b;
  assign w_diff    = r_a - r_b;
  assign w_slt     = ($signed(r_a) < $signed(r_b));

  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = w_sum;
      OP_SUB:  w_alu = w_diff;
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_SLL:  w_alu = r_a << w_shamt;
      OP_SRL:  w_alu = r_a >> w_shamt;
      OP_SRA:  w_alu = $signed(r_a) >>> w_shamt;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, w_slt};
      default: w_alu = '0;
    endcase
  end

  // Signed overflow: operands that agree in sign (ADD) or differ (SUB) yet flip the result sign.
  always_comb begin
    w_alu_ovf = 1'b0;
    if (r_op == OP_ADD)
      w_alu_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
    else if (r_op == OP_SUB)
      w_alu_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
  end

  assign w_mul_acc = r_acc + (r_sb[0] ? r_sa : '0);

  // Restoring step; a zero divisor always "fits", yielding all-ones quotient and remainder = a.
  assign w_rem_sh  = {r_rem, r_sa[WIDTH-1]};
  assign w_rem_ge  = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_sub = w_rem_sh - {1'b0, r_b};
  assign w_rem_nx  = w_rem_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_nx  = {r_acc[WIDTH-2:0], w_rem_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL)                         w_next = S_MUL;
          else if (op == OP_DIVU || op == OP_REMU)  w_next = S_DIV;
          else                                      w_next = S_ALU;
        end
      end
      S_ALU:   w_next = S_WB;
      S_MUL:   if (w_last) w_next = S_WB;
      S_DIV:   if (w_last) w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_WB);
    we   = (r_state == S_WB) && !r_err;
    ovf  = (r_state == S_WB) && r_ovf;
    err  = (r_state == S_WB) && r_err;
    wdst = r_dst;
    y    = r_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= '0;
      r_dst <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_acc <= '0;
      r_sa  <= '0;
      r_sb  <= '0;
      r_rem <= '0;
      r_y   <= '0;
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= op;
            r_dst <= dst;
            r_a   <= a;
            r_b   <= b;
            r_sa  <= a;
            r_sb  <= b;
            r_acc <= '0;
            r_rem <= '0;
            r_cnt <= '0;
          end
        end
        S_ALU: begin
          r_y   <= w_illegal ? '0 : w_alu;
          r_ovf <= w_illegal ? 1'b0 : w_alu_ovf;
          r_err <= w_illegal;
        end
        S_MUL: begin
          r_acc <= w_mul_acc;
          r_sa  <= r_sa << 1;
          r_sb  <= r_sb >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_y   <= w_mul_acc;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nx;
          r_acc <= w_quo_nx;
          r_sa  <= r_sa << 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_y   <= (r_op == OP_DIVU) ? w_quo_nx : w_rem_nx;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
